// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready request in, held response out, WAIT_STATES wait cycles.
// Optional macro DMEM_MISALIGN_CHECK_EN rejects word-misaligned addresses with rsp_err.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam bit         NO_WAIT   = (WAIT_STATES == 32'sd0);
    localparam logic [3:0] WAIT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 32'sd1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_accept;
    logic        w_commit;
    logic        w_cur_write;
    logic [31:0] w_cur_addr;
    logic [31:0] w_cur_wdata;
    logic        w_cur_err;
    logic [AW-1:0] w_idx;

    // Address rejection: anything above the array, plus misalignment when enabled.
    function automatic logic addr_err(input logic [31:0] a);
        logic [31:0] hi;
        logic        bad;
        hi  = a >> (AW + 2);
        bad = (hi != 32'd0);
`ifdef DMEM_MISALIGN_CHECK_EN
        bad = bad | (a[1:0] != 2'b00);
`endif
        return bad;
    endfunction

    assign w_accept = (r_state == S_IDLE) && req_valid;

    // With zero wait states the access commits on the accept edge, before the latches load.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_cur_write = req_write;
            w_cur_addr  = req_addr;
            w_cur_wdata = req_wdata;
        end else begin
            w_cur_write = r_write;
            w_cur_addr  = r_addr;
            w_cur_wdata = r_wdata;
        end
    end

    assign w_cur_err = addr_err(w_cur_addr);
    assign w_idx     = w_cur_addr[AW+1:2];

    // Next-state and commit decision.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (NO_WAIT) begin
                        w_state_nxt = S_RESP;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = WAIT_INIT;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                    w_commit    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // State, request latches and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_write     <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_req_ready <= (w_state_nxt == S_IDLE);
            r_rsp_valid <= (w_state_nxt == S_RESP);
            if (w_accept) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (w_commit) begin
                r_rsp_err   <= w_cur_err;
                r_rsp_rdata <= (w_cur_err || w_cur_write) ? 32'd0 : r_mem[w_idx];
            end else if ((r_state == S_RESP) && rsp_ready) begin
                r_rsp_err   <= 1'b0;
                r_rsp_rdata <= 32'd0;
            end
        end
    end

    // Word array: not reset; a reset in the commit cycle drops the store.
    always_ff @(posedge clk) begin
        if (!rst && w_commit && w_cur_write && !w_cur_err) begin
            r_mem[w_idx] <= w_cur_wdata;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
endmodule
